// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional fetch address-error checking is enabled by defining FETCH_ADEL_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] jr_addr,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic        id_bd,
    output logic        id_exc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_pc_q;
    logic        id_valid_q, id_bd_q, id_exc_q;

    logic [1:0]  eff_sel;
    logic [31:0] pc_plus4, id_pc_plus4, br_target, j_target;
    logic        adel;
    logic [31:0] fetch_word;

    assign pc_plus4    = pc_q + 32'd4;
    assign id_pc_plus4 = id_pc_q + 32'd4;
    assign br_target   = id_pc_plus4 + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    assign j_target    = {id_pc_plus4[31:28], id_instr_q[25:0], 2'b00};

    // A bubble in decode must not redirect fetch.
    assign eff_sel = id_valid_q ? npc_sel : 2'b00;

    always_comb begin
        pc_d = pc_plus4;
        if (exc_req) begin
            pc_d = EXC_VEC;
        end else if (eret) begin
            pc_d = epc;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            unique case (eff_sel)
                2'b00:   pc_d = pc_plus4;
                2'b01:   pc_d = br_taken ? br_target : pc_plus4;
                2'b10:   pc_d = j_target;
                2'b11:   pc_d = jr_addr;
                default: pc_d = pc_plus4;
            endcase
        end
    end

`ifdef FETCH_ADEL_CHECK_EN
    localparam logic [32:0] ImLo = {1'b0, RESET_PC};
    localparam logic [32:0] ImHi = ImLo + (33'(IM_WORDS) << 2);

    always_comb begin
        adel = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} < ImLo) || ({1'b0, pc_q} >= ImHi);
        fetch_word = adel ? 32'h0 : instr;
    end
`else
    always_comb begin
        adel       = 1'b0;
        fetch_word = instr;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            id_instr_q <= 32'h0;
            id_pc_q    <= 32'h0;
            id_valid_q <= 1'b0;
            id_bd_q    <= 1'b0;
            id_exc_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (exc_req || eret) begin
                id_instr_q <= 32'h0;
                id_pc_q    <= 32'h0;
                id_valid_q <= 1'b0;
                id_bd_q    <= 1'b0;
                id_exc_q   <= 1'b0;
            end else if (!stall) begin
                id_instr_q <= fetch_word;
                id_pc_q    <= pc_q;
                id_valid_q <= 1'b1;
                // Not-taken branches still mark their successor as a delay slot.
                id_bd_q    <= id_valid_q && (npc_sel != 2'b00);
                id_exc_q   <= adel;
            end
        end
    end

    assign pc       = pc_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_pc8   = id_pc_q + 32'd8;
    assign id_valid = id_valid_q;
    assign id_bd    = id_bd_q;
    assign id_exc   = id_exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF state is queued per step and checked after the edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n, stall, br_taken, exc_req, eret;
    logic [1:0]  npc_sel;
    logic [31:0] jr_addr, epc, instr;
    logic [31:0] pc, id_instr, id_pc, id_pc8;
    logic        id_valid, id_bd, id_exc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iinstr;
        logic        bd;
        logic        exc;
    } exp_t;

    exp_t sb[$];

    fetch_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .stall    (stall),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .jr_addr  (jr_addr),
        .exc_req  (exc_req),
        .eret     (eret),
        .epc      (epc),
        .instr    (instr),
        .pc       (pc),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .id_pc8   (id_pc8),
        .id_valid (id_valid),
        .id_bd    (id_bd),
        .id_exc   (id_exc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h1000_0003;  // beq, imm16 = 3
            32'h0000_3014: return 32'h0800_0C80;  // j 0x3200
            default:       return {16'hCAFE, a[15:0]};
        endcase
    endfunction

    function automatic logic adel_model(input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
`else
        return 1'b0;
`endif
    endfunction

    assign instr = imem(pc);

    task automatic drive(input logic rn, input logic st, input logic [1:0] sel, input logic br,
                         input logic [31:0] ja, input logic ex, input logic er,
                         input logic [31:0] ep);
        reset_n = rn; stall = st; npc_sel = sel; br_taken = br;
        jr_addr = ja; exc_req = ex; eret = er; epc = ep;
    endtask

    task automatic expect_st(input string tag, input logic [31:0] epc_v, input logic iv,
                             input logic [31:0] ipc, input logic bd);
        exp_t e;
        e.tag = tag; e.pc = epc_v; e.iv = iv; e.ipc = ipc; e.bd = bd;
        e.exc    = iv ? adel_model(ipc) : 1'b0;
        e.iinstr = (!iv || e.exc) ? 32'h0 : imem(ipc);
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "pc", pc, e.pc);
        chk(e.tag, "id_valid", {31'h0, id_valid}, {31'h0, e.iv});
        chk(e.tag, "id_pc", id_pc, e.ipc);
        chk(e.tag, "id_pc8", id_pc8, e.ipc + 32'd8);
        chk(e.tag, "id_instr", id_instr, e.iinstr);
        chk(e.tag, "id_bd", {31'h0, id_bd}, {31'h0, e.bd});
        chk(e.tag, "id_exc", {31'h0, id_exc}, {31'h0, e.exc});
    endtask

    initial begin
        // Reset for two edges, then sequential fetch.
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("rst0", 32'h3000, 0, 0, 0); tick();
        drive(0, 1, 2'b11, 0, 32'h1234, 1, 1, 32'h55); expect_st("rst1", 32'h3000, 0, 0, 0); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("seq0", 32'h3004, 1, 32'h3000, 0); tick();
        expect_st("seq1", 32'h3008, 1, 32'h3004, 0); tick();

        // Re-reset, then branch / jump / stall sequence.
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("rst2", 32'h3000, 0, 0, 0); tick();
        expect_st("rst3", 32'h3000, 0, 0, 0); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("fetch_beq", 32'h3004, 1, 32'h3000, 0); tick();
        drive(1, 0, 2'b01, 1, 0, 0, 0, 0); expect_st("beq_taken", 32'h3010, 1, 32'h3004, 1); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("br_target", 32'h3014, 1, 32'h3010, 0); tick();
        drive(1, 0, 2'b01, 0, 0, 0, 0, 0); expect_st("br_ntaken", 32'h3018, 1, 32'h3014, 1); tick();
        drive(1, 0, 2'b10, 0, 0, 0, 0, 0); expect_st("jump", 32'h3200, 1, 32'h3018, 1); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("j_target", 32'h3204, 1, 32'h3200, 0); tick();
        drive(1, 1, 2'b11, 0, 32'h3100, 0, 0, 0); expect_st("stall0", 32'h3204, 1, 32'h3200, 0); tick();
        expect_st("stall1", 32'h3204, 1, 32'h3200, 0); tick();
        drive(1, 0, 2'b11, 0, 32'h3100, 0, 0, 0); expect_st("jr", 32'h3100, 1, 32'h3204, 1); tick();

        // Exception / eret.
        drive(1, 0, 2'b00, 0, 0, 1, 1, 32'h3020); expect_st("exc_eret", 32'h4180, 0, 0, 0); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 1, 32'h3020); expect_st("eret", 32'h3020, 0, 0, 0); tick();
        drive(1, 0, 2'b11, 0, 32'hDEAD, 0, 0, 0); expect_st("sel_ignored", 32'h3024, 1, 32'h3020, 0); tick();
        drive(1, 1, 2'b00, 0, 0, 1, 0, 0); expect_st("exc_stall", 32'h4180, 0, 0, 0); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("vec_fetch", 32'h4184, 1, 32'h4180, 0); tick();

        // PC wrap.
        drive(1, 0, 2'b11, 0, 32'hFFFF_FFFC, 0, 0, 0);
        expect_st("jr_top", 32'hFFFF_FFFC, 1, 32'h4184, 1); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("wrap", 32'h0, 1, 32'hFFFF_FFFC, 0); tick();
        expect_st("low_pc", 32'h4, 1, 32'h0, 0); tick();

        // Address-error cases and the legal upper boundary.
        drive(1, 0, 2'b11, 0, 32'h3002, 0, 0, 0); expect_st("jr_mis", 32'h3002, 1, 32'h4, 1); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("adel_mis", 32'h3006, 1, 32'h3002, 0); tick();
        drive(1, 0, 2'b11, 0, 32'h7000, 0, 0, 0); expect_st("jr_oor", 32'h7000, 1, 32'h3006, 1); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("adel_oor", 32'h7004, 1, 32'h7000, 0); tick();
        drive(1, 0, 2'b11, 0, 32'h6FFC, 0, 0, 0); expect_st("jr_last", 32'h6FFC, 1, 32'h7004, 1); tick();
        drive(1, 0, 2'b00, 0, 0, 0, 0, 0); expect_st("last_ok", 32'h7000, 1, 32'h6FFC, 0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter that addresses the combinational instruction memory, computes the next PC (sequential, branch, jump, register jump, exception vector, eret return), and registers the fetched word into the IF/ID pipeline register. It supports stall, flush and branch delay slot semantics, and can optionally check fetch addresses. It sits between the hazard/branch logic of the decode stage and the instruction memory, and feeds decode.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VEC, 32'h0000_4180, exception entry address
- IM_WORDS, 4096, instruction memory depth in words; the legal fetch range is [RESET_PC, RESET_PC + 4*IM_WORDS)

- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and IF/ID
- npc_sel  in  2  decode-stage redirect: 00 seq, 01 branch, 10 j/jal, 11 jr
- br_taken  in  1  branch condition; only used when npc_sel=01
- jr_addr  in  32  forwarded rs value for jr/jalr
- exc_req  in  1  exception taken by a later stage
- eret  in  1  eret committed
- epc  in  32  return address for eret
- instr  in  32  word from instruction memory at pc
- pc  out  32  fetch address driven to instruction memory
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID PC
- id_pc8  out  32  id_pc + 8, the link value (combinational from register)
- id_valid  out  1  IF/ID holds a real instruction
- id_bd  out  1  IF/ID instruction is in a branch delay slot
- id_exc  out  1  fetch address error (AdEL) on the IF/ID instruction

## Operation
- Resolve the redirect in priority order:
  - exc_req: next pc = EXC_VEC.
  - eret: next pc = epc.
  - stall: hold.
  - Otherwise use npc_sel.
- npc_sel is ignored (treated as 00) when id_valid=0.
- Redirect targets, all arithmetic mod 2^32:
  - seq: pc+4.
  - branch: if br_taken, id_pc + 4 + sext(id_instr[15:0])<<2; else pc+4.
  - j: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - jr: jr_addr.
- IF/ID update:
  - exc_req or eret: flush. instr=0, pc=0, valid=0, bd=0, exc=0. No delay slot is kept.
  - stall (and no exc_req/eret): all IF/ID fields hold.
  - Otherwise capture: id_instr=instr, id_pc=pc, id_valid=1.
  - On capture, id_bd=1 iff id_valid=1 and npc_sel!=00 at that edge. A not-taken branch still sets bd.
- Delay slot: the instruction at pc when a branch/jump is in decode is always captured and executed.

## Timing
- Reset: on a clock edge with reset_n=0, pc=RESET_PC and id_instr=0, id_pc=0, id_valid=0, id_bd=0, id_exc=0. Reset dominates exc_req, eret and stall.
- pc is registered. instr is valid in the same cycle, combinational from memory. The fetched word reaches decode one edge later.
- Redirect latency: a branch in decode redirects pc at the next edge. There is exactly one delay slot and zero bubbles.
- exc_req arriving during stall still redirects and flushes on that edge.
- exc_req and eret asserted together: exc_req wins.
- PC wrap past 32'hFFFF_FFFC: wraps to 0. The AdEL check flags it if enabled.

## Configuration
- FETCH_ADEL_CHECK_EN defined:
  - On capture, id_exc = (pc[1:0]!=0) or pc outside the legal range.
  - When id_exc=1, id_instr is forced to 0 (nop).
- FETCH_ADEL_CHECK_EN undefined:
  - id_exc is constant 0 and instr passes through unmodified.
  - Out-of-range PCs index memory modulo its depth.

## Test plan
- Reset low for 2 edges, then release. Required: pc=0x3000, 0x3004, 0x3008 on successive edges; id_valid=0 for the first cycle after release, then 1 with id_pc=0x3000.
- beq at 0x3000 with imm16=0x0003, br_taken=1. Required: the delay slot at 0x3004 is captured with id_bd=1, then pc=0x3010.
- jr with jr_addr=0x3100 while stall=1 for 2 cycles. Required: pc and IF/ID hold for both cycles; after stall drops, pc=0x3100.
- exc_req=1 and eret=1 together with epc=0x3020. Required: pc=0x4180, IF/ID flushed (id_valid=0). Then eret alone gives pc=0x3020.
- With FETCH_ADEL_CHECK_EN, jr_addr=0x3002. Required: id_exc=1, id_instr=0, id_pc=0x3002. Same for jr_addr=0x7000. Without the macro, id_exc stays 0.
